// File: rtl/ball_motion_controller.sv
// Per-frame ball update: move, player proximity test, collider handshake and wall fold.
// Publishes the resulting position to rendering.
module ball_motion_controller #(
  parameter int START_X         = 320,
  parameter int START_Y         = 240,
  parameter int START_DIR_X     = 2,
  parameter int START_DIR_Y     = 1,
  parameter int HIT_RADIUS      = 16,
  parameter int SETTLE_CYCLES   = 2,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  output logic [18:0]        old_ball_x,
  output logic [18:0]        old_ball_y,
  output logic [18:0]        old_ball_dir_x,
  output logic [18:0]        old_ball_dir_y,
  input  logic signed [18:0] new_ball_x,
  input  logic signed [18:0] new_ball_y,
  input  logic signed [18:0] new_ball_dir_x,
  input  logic signed [18:0] new_ball_dir_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               busy,
  output logic               update_done,
  output logic [7:0]         hit_count,
  output logic               frame_overrun
);

  typedef enum logic [2:0] {IDLE, MOVE, CHECK, SOLVE, CAPTURE, WALL, DONE} state_t;

  localparam logic signed [18:0] XMAX_S   = 19'(X_MAX);
  localparam logic signed [18:0] YMAX_S   = 19'(Y_MAX);
  localparam logic signed [18:0] RADIUS_S = 19'(HIT_RADIUS);

  state_t             state_q, state_d;
  logic signed [18:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [18:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic [7:0]         cooldown_q, cooldown_d;
  logic [7:0]         settle_q, settle_d;
  logic               overrun_q, overrun_d;

  logic signed [18:0] dx, dy, fold_x, fold_y;
  logic               flip_x, flip_y, in_radius;

  // Returns {direction flip, folded-and-clamped position} for one axis.
  function automatic logic [19:0] wallFold(input logic signed [18:0] p,
                                           input logic signed [18:0] maxv);
    logic signed [18:0] r;
    logic               flip;
    r    = p;
    flip = 1'b0;
    if (p < 0) begin
      r    = -p;
      flip = 1'b1;
    end else if (p > maxv) begin
      r    = (maxv <<< 1) - p;
      flip = 1'b1;
    end
    if (r < 0) r = '0;
    else if (r > maxv) r = maxv;
    return {flip, r};
  endfunction

  assign dx = pos_x_q - $signed({9'b0, player_x});
  assign dy = pos_y_q - $signed({9'b0, player_y});
  assign in_radius = (dx >= -RADIUS_S) && (dx <= RADIUS_S) &&
                     (dy >= -RADIUS_S) && (dy <= RADIUS_S);
  assign {flip_x, fold_x} = wallFold(pos_x_q, XMAX_S);
  assign {flip_y, fold_y} = wallFold(pos_y_q, YMAX_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_x_q     <= 19'(START_X);
      pos_y_q     <= 19'(START_Y);
      dir_x_q     <= 19'(START_DIR_X);
      dir_y_q     <= 19'(START_DIR_Y);
      hit_count_q <= '0;
      cooldown_q  <= '0;
      settle_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      hit_count_q <= hit_count_d;
      cooldown_q  <= cooldown_d;
      settle_q    <= settle_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    hit_count_d = hit_count_q;
    cooldown_d  = cooldown_q;
    settle_d    = settle_q;
    overrun_d   = overrun_q | (frame_tick && (state_q != IDLE));
    case (state_q)
      IDLE: if (frame_tick) state_d = MOVE;
      MOVE: begin
        pos_x_d = pos_x_q + dir_x_q;
        pos_y_d = pos_y_q + dir_y_q;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = WALL;
        if (cooldown_q != 8'd0) begin
          cooldown_d = cooldown_q - 8'd1;
        end else if (in_radius) begin
          // A head-on vertical hit has no usable slope, so it is resolved locally.
          if (dx != 19'sd0) begin
            state_d  = SOLVE;
            settle_d = '0;
          end else begin
            dir_y_d     = -dir_y_q;
            hit_count_d = hit_count_q + 8'd1;
            cooldown_d  = 8'(COOLDOWN_FRAMES);
          end
        end
      end
      SOLVE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == 8'(SETTLE_CYCLES - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        pos_x_d     = new_ball_x;
        pos_y_d     = new_ball_y;
        dir_x_d     = new_ball_dir_x;
        dir_y_d     = new_ball_dir_y;
        hit_count_d = hit_count_q + 8'd1;
        cooldown_d  = 8'(COOLDOWN_FRAMES);
        state_d     = WALL;
      end
      WALL: begin
        pos_x_d = fold_x;
        pos_y_d = fold_y;
        if (flip_x) dir_x_d = -dir_x_q;
        if (flip_y) dir_y_d = -dir_y_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign old_ball_x     = pos_x_q;
  assign old_ball_y     = pos_y_q;
  assign old_ball_dir_x = dir_x_q;
  assign old_ball_dir_y = dir_y_q;
  assign ball_x         = pos_x_q[9:0];
  assign ball_y         = pos_y_q[9:0];
  assign busy           = (state_q != IDLE);
  assign update_done    = (state_q == DONE);
  assign hit_count      = hit_count_q;
  assign frame_overrun  = overrun_q;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench for ball_motion_controller: a frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_ball_motion_controller;

  localparam int S = 2, COOL = 4, R = 16, XM = 639, YM = 479;

  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, tick_w = 1'b0;
  logic [9:0] player_x = '0, player_y = '0;
  logic signed [18:0] new_ball_x = '0, new_ball_y = '0, new_ball_dir_x = '0, new_ball_dir_y = '0;
  logic [18:0] old_ball_x, old_ball_y, old_ball_dir_x, old_ball_dir_y;
  logic [9:0]  ball_x, ball_y;
  logic        busy, update_done, frame_overrun;
  logic [7:0]  hit_count;
  logic [18:0] w_old_x, w_old_y, w_old_dx, w_old_dy;
  logic [9:0]  w_ball_x, w_ball_y;
  logic        w_busy, w_done, w_ovr;
  logic [7:0]  w_hits;

  ball_motion_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y),
    .old_ball_x(old_ball_x), .old_ball_y(old_ball_y),
    .old_ball_dir_x(old_ball_dir_x), .old_ball_dir_y(old_ball_dir_y),
    .new_ball_x(new_ball_x), .new_ball_y(new_ball_y),
    .new_ball_dir_x(new_ball_dir_x), .new_ball_dir_y(new_ball_dir_y),
    .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .update_done(update_done),
    .hit_count(hit_count), .frame_overrun(frame_overrun)
  );

  // Second instance starting near the right wall.
  ball_motion_controller #(.START_X(637), .START_DIR_X(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .frame_tick(tick_w),
    .player_x(player_x), .player_y(player_y),
    .old_ball_x(w_old_x), .old_ball_y(w_old_y),
    .old_ball_dir_x(w_old_dx), .old_ball_dir_y(w_old_dy),
    .new_ball_x(new_ball_x), .new_ball_y(new_ball_y),
    .new_ball_dir_x(new_ball_dir_x), .new_ball_dir_y(new_ball_dir_y),
    .ball_x(w_ball_x), .ball_y(w_ball_y), .busy(w_busy), .update_done(w_done),
    .hit_count(w_hits), .frame_overrun(w_ovr)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference model: whole frame outcome is computed when a tick is accepted.
  int m_px = 320, m_py = 240, m_dx = 2, m_dy = 1, m_hits = 0, m_cool = 0, m_ovr = 0;
  int m_n = -100, m_done = -100, m_solve = 0;
  int c_px = 0, c_py = 0, c_dx = 0, c_dy = 0;
  int cyc = 0;

  task automatic wallAxis(inout int p, inout int d, input int mx);
    if (p < 0) begin p = -p; d = -d; end
    else if (p > mx) begin p = 2 * mx - p; d = -d; end
    if (p < 0) p = 0;
    else if (p > mx) p = mx;
  endtask

  task automatic runFrame(input int n);
    int ddx, ddy;
    m_px += m_dx; m_py += m_dy;
    c_px = m_px; c_py = m_py; c_dx = m_dx; c_dy = m_dy;
    m_solve = 0;
    ddx = m_px - int'(player_x);
    ddy = m_py - int'(player_y);
    if (m_cool > 0) m_cool--;
    else if (ddx >= -R && ddx <= R && ddy >= -R && ddy <= R) begin
      if (ddx != 0) begin
        m_solve = 1;
        m_px = int'(new_ball_x); m_py = int'(new_ball_y);
        m_dx = int'(new_ball_dir_x); m_dy = int'(new_ball_dir_y);
      end else m_dy = -m_dy;
      m_hits = (m_hits + 1) % 256;
      m_cool = COOL;
    end
    wallAxis(m_px, m_dx, XM);
    wallAxis(m_py, m_dy, YM);
    m_n = n;
    m_done = n + (m_solve != 0 ? 5 + S : 4);
  endtask

  // Model advance: reset asynchronously, otherwise consume the tick seen at this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_px = 320; m_py = 240; m_dx = 2; m_dy = 1;
      m_hits = 0; m_cool = 0; m_ovr = 0; m_solve = 0;
      m_n = -100; m_done = -100;
    end else begin
      if (frame_tick) begin
        if (cyc > m_done) runFrame(cyc);
        else m_ovr = 1;
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", int'(busy), int'(cyc > m_n && cyc <= m_done));
      checkOutput("update_done", int'(update_done), int'(cyc == m_done));
      checkOutput("frame_overrun", int'(frame_overrun), m_ovr);
      if (cyc >= m_done) begin
        checkOutput("ball_x", int'(ball_x), m_px & 1023);
        checkOutput("ball_y", int'(ball_y), m_py & 1023);
        checkOutput("old_ball_x", int'($signed(old_ball_x)), m_px);
        checkOutput("old_ball_y", int'($signed(old_ball_y)), m_py);
        checkOutput("dir_x", int'($signed(old_ball_dir_x)), m_dx);
        checkOutput("dir_y", int'($signed(old_ball_dir_y)), m_dy);
        checkOutput("hit_count", int'(hit_count), m_hits);
      end else if (m_solve != 0 && cyc >= m_n + 2 && cyc <= m_n + 3 + S) begin
        checkOutput("held_x", int'($signed(old_ball_x)), c_px);
        checkOutput("held_y", int'($signed(old_ball_y)), c_py);
        checkOutput("held_dir_x", int'($signed(old_ball_dir_x)), c_dx);
        checkOutput("held_dir_y", int'($signed(old_ball_dir_y)), c_dy);
      end
    end
  end

  task automatic applyStimulus(input int px, input int py, input int nx, input int ny,
                               input int ndx, input int ndy);
    player_x = px[9:0]; player_y = py[9:0];
    new_ball_x = 19'(nx); new_ball_y = 19'(ny);
    new_ball_dir_x = 19'(ndx); new_ball_dir_y = 19'(ndy);
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    int i;
    lat = 0; i = 0;
    while (lat == 0 && i < 40) begin
      i++;
      @(negedge clk);
      if (update_done) lat = i;
    end
    if (lat == 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ball_x"}, int'(ball_x), 320);
    checkOutput({tag, "_ball_y"}, int'(ball_y), 240);
    checkOutput({tag, "_dir_x"}, int'($signed(old_ball_dir_x)), 2);
    checkOutput({tag, "_dir_y"}, int'($signed(old_ball_dir_y)), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(update_done), 0);
    checkOutput({tag, "_hits"}, int'(hit_count), 0);
    checkOutput({tag, "_ovr"}, int'(frame_overrun), 0);
  endtask

  initial begin
    int lat, px, py, off;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Collider hit with literal expectations.
    applyStimulus(330, 240, 318, 239, -4, -2);
    pulseTick();
    repeat (3) @(negedge clk);
    checkOutput("solve_old_x", int'(old_ball_x), 322);
    checkOutput("solve_old_y", int'(old_ball_y), 241);
    checkOutput("solve_dir_x", int'(old_ball_dir_x), 2);
    checkOutput("solve_dir_y", int'(old_ball_dir_y), 1);
    repeat (3) @(negedge clk);
    checkOutput("hit_done_n6", int'(update_done), 0);
    @(negedge clk);
    checkOutput("hit_done_n7", int'(update_done), 1);
    checkOutput("hit_ball_x", int'(ball_x), 318);
    checkOutput("hit_ball_y", int'(ball_y), 239);
    checkOutput("hit_dir_x", int'($signed(old_ball_dir_x)), -4);
    checkOutput("hit_dir_y", int'($signed(old_ball_dir_y)), -2);
    checkOutput("hit_count1", int'(hit_count), 1);

    // Reset in the middle of SOLVE.
    nextCycle(); rst_n = 1'b0; nextCycle(); rst_n = 1'b1; nextCycle();
    pulseTick();
    nextCycle(); nextCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("midrst");
    nextCycle(); rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle_busy", int'(busy), 0);
    nextCycle();

    // Free flight, three ticks ten cycles apart.
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      pulseTick();
      waitDone(lat);
      checkOutput("free_latency", lat, 4);
      repeat (6) nextCycle();
    end
    checkOutput("free_ball_x", int'(ball_x), 326);
    checkOutput("free_ball_y", int'(ball_y), 243);
    checkOutput("free_hits", int'(hit_count), 0);

    // Cooldown and dx=0 path; player sits where the ball will land.
    nextCycle(); rst_n = 1'b0; nextCycle(); rst_n = 1'b1; nextCycle();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(322 + 2 * k, 241 - (k == 0 ? 0 : k - 2 * (k > 0 ? 1 : 0) + 0), 0, 0, 0, 0);
      if (k > 0) applyStimulus(322 + 2 * k, 242 - k, 0, 0, 0, 0);
      pulseTick();
      waitDone(lat);
      checkOutput("cool_latency", lat, 4);
      if (k == 0) begin
        checkOutput("dx0_dir_y", int'($signed(old_ball_dir_y)), -1);
        checkOutput("dx0_hits", int'(hit_count), 1);
      end
      if (k == 4) checkOutput("cool_hits", int'(hit_count), 1);
      nextCycle();
    end
    checkOutput("cool_hits2", int'(hit_count), 2);
    checkOutput("cool_dir_y", int'($signed(old_ball_dir_y)), 1);

    // Overrun: second tick during the update.
    applyStimulus(0, 0, 0, 0, 0, 0);
    pulseTick();
    nextCycle();
    pulseTick();
    @(negedge clk);
    checkOutput("ovr_done_n3", int'(update_done), 0);
    @(negedge clk);
    checkOutput("ovr_done_n4", int'(update_done), 1);
    checkOutput("ovr_ball_x", int'(ball_x), 334);
    checkOutput("ovr_ball_y", int'(ball_y), 237);
    checkOutput("ovr_flag", int'(frame_overrun), 1);
    nextCycle();

    // Right-wall reflection on the second instance.
    tick_w = 1'b1; nextCycle(); tick_w = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("wall_done", int'(w_done), 1);
    checkOutput("wall_ball_x", int'(w_ball_x), 637);
    checkOutput("wall_ball_y", int'(w_ball_y), 241);
    checkOutput("wall_dir_x", int'($signed(w_old_dx)), -4);
    nextCycle();

    // Randomized frames against the model.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        off = int'($urandom_range(0, 40)) - 20;
        if ($urandom_range(0, 3) == 0) off = 0;
        px = m_px + m_dx + off;
        py = m_py + m_dy + int'($urandom_range(0, 40)) - 20;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      px = (px < 0) ? 0 : (px > 1023 ? 1023 : px);
      py = (py < 0) ? 0 : (py > 1023 ? 1023 : py);
      applyStimulus(px, py, int'($urandom_range(0, 2100)) - 700, int'($urandom_range(0, 1700)) - 600,
                    int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30);
      pulseTick();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 2)) nextCycle();
        pulseTick();
      end
      waitDone(lat);
      repeat ($urandom_range(0, 2)) nextCycle();
      nextCycle();
    end

    repeat (3) nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
